// File: rtl/forney_pkg.sv
// rtl/forney_pkg.sv - shared state encoding and sizing constants for the Forney frame controller
package forney_pkg;

  localparam int T       = 11;
  localparam int LANES   = 32;
  localparam int DEG_W   = 4;
  localparam int CNT_W   = 4;
  localparam int TMO_W   = 8;
  localparam int SAT_LIM = T + 1;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    DRAIN,
    FLUSH,
    REPORT
  } state_t;

endpackage

// File: rtl/forney_frame_ctrl_hit_popcount_sat.sv
// rtl/forney_frame_ctrl_hit_popcount_sat.sv - combinational lane popcount clipped to the saturation limit
module hit_popcount_sat #(
  parameter int LANES = 32,
  parameter int CNT_W = 4,
  parameter int SAT   = 12
) (
  input  logic [LANES-1:0] hit_mask,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int SUM_W = $clog2(LANES + 1);
  localparam logic [SUM_W-1:0] SAT_S = SUM_W'(SAT);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(hit_mask[i]);
    end
    hit_cnt = (sum > SAT_S) ? CNT_W'(SAT) : CNT_W'(sum);
  end

endmodule

// File: rtl/forney_frame_ctrl.sv
// rtl/forney_frame_ctrl.sv - per-codeword Forney sequencer: hit/emit counting, verdict, flush
// Optional drain watchdog enabled by FORNEY_DRAIN_TIMEOUT_EN.
module forney_frame_ctrl
  import forney_pkg::*;
#(
  parameter int LANES = forney_pkg::LANES,
  parameter int T     = forney_pkg::T,
  parameter int DEG_W = forney_pkg::DEG_W,
  parameter int CNT_W = forney_pkg::CNT_W,
  parameter int TMO_W = forney_pkg::TMO_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cw_start_i,
  input  logic [DEG_W-1:0] deg_lambda_i,
  input  logic             chien_vld_i,
  input  logic [LANES-1:0] hit_mask_i,
  input  logic             chien_last_i,
  input  logic             fny_vld_i,
  input  logic             corr_rdy_i,
  input  logic             abort_i,
  output logic             s1_rdy_o,
  output logic             fny_flush_o,
  output logic             busy_o,
  output logic             cw_done_o,
  output logic             cw_fail_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             proto_err_o
);

  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(T + 1);

  state_t           state_q, state_d;
  logic [DEG_W-1:0] deg_q, deg_d;
  logic [CNT_W-1:0] hit_q, hit_d, emit_q, emit_d;
  logic             fail_q, fail_d, verdict_q, verdict_d;
  logic [CNT_W-1:0] batch_cnt, hit_new, hit_eff, emit_inc;
  logic [CNT_W:0]   hit_sum;
  logic             evt_err, tmo_hit;

  hit_popcount_sat #(
    .LANES (LANES),
    .CNT_W (CNT_W),
    .SAT   (T + 1)
  ) u_popcount (
    .hit_mask (hit_mask_i),
    .hit_cnt  (batch_cnt)
  );

  assign hit_sum  = {1'b0, hit_q} + {1'b0, batch_cnt};
  assign hit_new  = (hit_sum > {1'b0, SAT_C}) ? SAT_C : hit_sum[CNT_W-1:0];
  assign emit_inc = (emit_q == SAT_C) ? emit_q : emit_q + CNT_W'(1);

`ifdef FORNEY_DRAIN_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  assign tmo_hit = (tmo_q == '1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (state_q != DRAIN || fny_vld_i) begin
      tmo_q <= '0;
    end else if (!tmo_hit) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  // No watchdog: DRAIN waits for the serializer without bound.
  assign tmo_hit = (TMO_W < 0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      deg_q     <= '0;
      hit_q     <= '0;
      emit_q    <= '0;
      fail_q    <= 1'b0;
      verdict_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deg_q     <= deg_d;
      hit_q     <= hit_d;
      emit_q    <= emit_d;
      fail_q    <= fail_d;
      verdict_q <= verdict_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deg_d     = deg_q;
    hit_d     = hit_q;
    emit_d    = emit_q;
    fail_d    = fail_q;
    verdict_d = verdict_q;
    hit_eff   = hit_q;
    evt_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cw_start_i) begin
          deg_d     = deg_lambda_i;
          hit_d     = '0;
          emit_d    = '0;
          fail_d    = 1'b0;
          verdict_d = 1'b0;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        if (chien_vld_i) begin
          hit_eff = hit_new;
          hit_d   = hit_new;
          if (chien_last_i) state_d = DRAIN;
        end
        // An emission is legal only while it stays within the roots found so far.
        if (fny_vld_i) begin
          if (emit_q >= hit_eff) begin
            evt_err = 1'b1;
            fail_d  = 1'b1;
            state_d = FLUSH;
          end else begin
            emit_d = emit_inc;
          end
        end
      end
      DRAIN: begin
        evt_err = chien_vld_i;
        if (hit_q == SAT_C) begin
          fail_d  = 1'b1;
          state_d = FLUSH;
        end else if (fny_vld_i && emit_q >= hit_q) begin
          evt_err = 1'b1;
          fail_d  = 1'b1;
          state_d = FLUSH;
        end else if (fny_vld_i) begin
          emit_d = emit_inc;
        end else if (tmo_hit) begin
          evt_err = 1'b1;
          fail_d  = 1'b1;
          state_d = FLUSH;
        end else if (emit_q == hit_q) begin
          state_d = REPORT;
        end
      end
      FLUSH:   state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever else happened this cycle.
    if (abort_i && state_q != IDLE) begin
      state_d = FLUSH;
      fail_d  = 1'b1;
      hit_d   = hit_q;
      emit_d  = emit_q;
      evt_err = 1'b0;
    end

    if (state_d == REPORT) begin
      verdict_d = fail_d | (int'(hit_d) != int'(deg_q)) | (int'(deg_q) > T);
    end
  end

  assign s1_rdy_o    = corr_rdy_i & (state_q == SEARCH || state_q == DRAIN);
  assign fny_flush_o = (state_q == FLUSH);
  assign busy_o      = (state_q != IDLE);
  assign cw_done_o   = (state_q == REPORT);
  assign cw_fail_o   = verdict_q;
  assign err_cnt_o   = hit_q;
  assign proto_err_o = evt_err | (cw_start_i & (state_q != IDLE));

endmodule

// File: tb/tb_forney_frame_ctrl.sv
// tb/tb_forney_frame_ctrl.sv - vector table, directed corner sequences and random codewords vs. a verdict model
module tb_forney_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cw_start = 1'b0;
  logic [3:0]  deg_lambda = '0;
  logic        chien_vld = 1'b0;
  logic [31:0] hit_mask = '0;
  logic        chien_last = 1'b0;
  logic        fny_vld = 1'b0;
  logic        corr_rdy = 1'b1;
  logic        abort = 1'b0;
  logic        s1_rdy, fny_flush, busy, cw_done, cw_fail, proto_err;
  logic [3:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  forney_frame_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cw_start_i   (cw_start),
    .deg_lambda_i (deg_lambda),
    .chien_vld_i  (chien_vld),
    .hit_mask_i   (hit_mask),
    .chien_last_i (chien_last),
    .fny_vld_i    (fny_vld),
    .corr_rdy_i   (corr_rdy),
    .abort_i      (abort),
    .s1_rdy_o     (s1_rdy),
    .fny_flush_o  (fny_flush),
    .busy_o       (busy),
    .cw_done_o    (cw_done),
    .cw_fail_o    (cw_fail),
    .err_cnt_o    (err_cnt),
    .proto_err_o  (proto_err)
  );

  typedef struct {
    int          deg;
    logic [31:0] m0;
    logic [31:0] m1;
    int          nb;
    int          emits;
    int          abort_k;
    int          e_err;
    int          e_fail;
    int          e_flush;
    int          e_proto;
    int          e_lat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_cw(input int deg);
    cw_start   = 1'b1;
    deg_lambda = 4'(deg);
    @(posedge clk); #1;
    cw_start   = 1'b0;
  endtask

  task automatic send_batches(input logic [31:0] m0, input logic [31:0] m1, input int nb);
    for (int b = 0; b < nb; b++) begin
      chien_vld  = 1'b1;
      hit_mask   = (b == 0) ? m0 : m1;
      chien_last = (b == nb - 1);
      @(posedge clk); #1;
    end
    chien_vld  = 1'b0;
    hit_mask   = '0;
    chien_last = 1'b0;
  endtask

  // Runs from the cycle after the last batch until cw_done; lat counts cycles from that batch.
  task automatic drain_window(input int emits, input int abort_k, output int lat, output int fail,
                              output int err, output int nflush, output int nproto);
    lat = -1; fail = 0; err = 0; nflush = 0; nproto = 0;
    for (int k = 1; k <= 400; k++) begin
      fny_vld = (k <= emits);
      abort   = (k == abort_k);
      @(negedge clk);
      nflush += int'(fny_flush);
      nproto += int'(proto_err);
      if (cw_done) begin
        lat  = k;
        fail = int'(cw_fail);
        err  = int'(err_cnt);
      end
      @(posedge clk); #1;
      if (lat > 0) break;
    end
    fny_vld = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_done_after"}, int'(cw_done), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, fail, err, nflush, nproto;
    int total, m_err, m_fail, m_lat, deg, nb, done_seen, s1_hi, fail_seen;
    logic [31:0] m0, m1;
    bit ovf;

    //           deg  m0            m1            nb emit abk err fail flush proto lat
    tbl[0] = '{3,  32'h0000_0105, 32'h0,        1, 3,  0,  3,  0,   0,    0,    5};
    tbl[1] = '{4,  32'h0000_0007, 32'h0,        1, 3,  0,  3,  1,   0,    0,    5};
    tbl[2] = '{11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0,  12, 1,   1,    0,    3};
    tbl[3] = '{0,  32'h0,         32'h0,        1, 0,  0,  0,  0,   0,    0,    2};
    tbl[4] = '{1,  32'h0000_0001, 32'h0,        1, 2,  0,  1,  1,   1,    1,    4};
    tbl[5] = '{12, 32'h0000_0FFF, 32'h0,        1, 0,  0,  12, 1,   1,    0,    3};
    tbl[6] = '{11, 32'h0000_07FF, 32'h0,        1, 11, 0,  11, 0,   0,    0,    13};
    tbl[7] = '{15, 32'h0,         32'h0,        1, 0,  0,  0,  1,   0,    0,    2};
    tbl[8] = '{4,  32'h0000_0003, 32'h0003_0000, 2, 4, 0,  4,  0,   0,    0,    6};
    tbl[9] = '{3,  32'h0000_0007, 32'h0,        1, 0,  2,  3,  1,   1,    0,    4};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_s1_rdy", int'(s1_rdy), 0);
    check("rst_done", int'(cw_done), 0);
    check("rst_fail", int'(cw_fail), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_flush", int'(fny_flush), 0);
    check("rst_proto", int'(proto_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      start_cw(tbl[i].deg);
      send_batches(tbl[i].m0, tbl[i].m1, tbl[i].nb);
      drain_window(tbl[i].emits, tbl[i].abort_k, lat, fail, err, nflush, nproto);
      check($sformatf("row%0d_lat", i), lat, tbl[i].e_lat);
      check($sformatf("row%0d_err_cnt", i), err, tbl[i].e_err);
      check($sformatf("row%0d_fail", i), fail, tbl[i].e_fail);
      check($sformatf("row%0d_flush", i), nflush, tbl[i].e_flush);
      check($sformatf("row%0d_proto", i), nproto, tbl[i].e_proto);
      check_idle_after($sformatf("row%0d", i));
    end

    // cw_start while searching: flagged and ignored, the first degree is kept
    start_cw(2);
    cw_start   = 1'b1;
    deg_lambda = 4'd5;
    @(negedge clk);
    check("restart_proto", int'(proto_err), 1);
    check("search_s1_rdy", int'(s1_rdy), 1);
    @(posedge clk); #1;
    cw_start = 1'b0;
    send_batches(32'h0000_0003, 32'h0, 1);
    drain_window(2, 0, lat, fail, err, nflush, nproto);
    check("restart_lat", lat, 4);
    check("restart_fail", fail, 0);
    check("restart_err_cnt", err, 2);
    check_idle_after("restart");

    // Downstream stall in DRAIN
    start_cw(2);
    send_batches(32'h0000_0003, 32'h0, 1);
    corr_rdy  = 1'b0;
    done_seen = 0;
    s1_hi     = 0;
    fail_seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      done_seen += int'(cw_done);
      s1_hi     += int'(s1_rdy);
      if (cw_done) fail_seen = int'(cw_fail);
      @(posedge clk); #1;
    end
`ifdef FORNEY_DRAIN_TIMEOUT_EN
    check("stall_timeout_done", done_seen, 1);
    check("stall_timeout_fail", fail_seen, 1);
    corr_rdy = 1'b1;
    check_idle_after("stall");
`else
    check("stall_no_done", done_seen, 0);
    check("stall_s1_rdy_low", s1_hi, 0);
    corr_rdy = 1'b1;
    @(negedge clk);
    check("stall_busy", int'(busy), 1);
    check("stall_s1_rdy_high", int'(s1_rdy), 1);
    @(posedge clk); #1;
    drain_window(2, 0, lat, fail, err, nflush, nproto);
    check("stall_release_lat", lat, 4);
    check("stall_release_fail", fail, 0);
    check_idle_after("stall");
`endif

    // Randomized codewords against the verdict model
    for (int r = 0; r < 25; r++) begin
      nb = int'($urandom_range(1, 2));
      case ($urandom_range(0, 3))
        0:       m0 = 32'hFFFF_FFFF;
        1:       m0 = '0;
        default: m0 = $urandom & $urandom & $urandom;
      endcase
      m1    = $urandom & $urandom & $urandom;
      total = $countones(m0) + ((nb == 2) ? $countones(m1) : 0);
      ovf   = (total >= 12);
      m_err = ovf ? 12 : total;
      if ($urandom_range(0, 2) != 0) deg = (m_err > 15) ? 15 : m_err;
      else deg = int'($urandom_range(0, 15));
      m_fail = (ovf || m_err != deg || deg > 11) ? 1 : 0;
      m_lat  = ovf ? 3 : m_err + 2;
      start_cw(deg);
      send_batches(m0, m1, nb);
      drain_window(ovf ? 0 : m_err, 0, lat, fail, err, nflush, nproto);
      check($sformatf("rnd%0d_lat", r), lat, m_lat);
      check($sformatf("rnd%0d_err_cnt", r), err, m_err);
      check($sformatf("rnd%0d_fail", r), fail, m_fail);
      check($sformatf("rnd%0d_flush", r), nflush, ovf ? 1 : 0);
      check($sformatf("rnd%0d_proto", r), nproto, 0);
      check_idle_after($sformatf("rnd%0d", r));
    end

    // Asynchronous reset mid-codeword
    start_cw(3);
    chien_vld = 1'b1;
    hit_mask  = 32'h0000_0001;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_err_cnt", int'(err_cnt), 0);
    check("async_rst_flush", int'(fny_flush), 0);
    check("async_rst_done", int'(cw_done), 0);
    chien_vld = 1'b0;
    hit_mask  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
